// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared definitions for the unified memory port arbiter: FSM state
//   encodings and owner codes used by the top and the winner-select logic.
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_e;

    // Owner codes: which master an access belongs to.
    localparam logic OWN_M0 = 1'b0;   // multicycle CPU
    localparam logic OWN_M1 = 1'b1;   // program loader / debug DMA

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pick
//   Combinational winner select between the two memory masters.
//   Build option MEM_ARB_RR_EN:
//     defined   - round-robin: on a tie the master not granted last wins.
//     undefined - fixed priority: m0 (CPU) wins every tie.
//   A single requester always wins in both builds.
// Ports
//   m0_req_i   in  1  CPU request
//   m1_req_i   in  1  loader/DMA request
//   rr_ptr_i   in  1  owner of the most recent grant
//   gnt_any_o  out 1  at least one request present
//   gnt_own_o  out 1  winning owner (OWN_M0 / OWN_M1), valid with gnt_any_o
// ---------------------------------------------------------------------------
module mem_port_arbiter_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic m0_req_i,
    input  logic m1_req_i,
    input  logic rr_ptr_i,
    output logic gnt_any_o,
    output logic gnt_own_o
);

    assign gnt_any_o = m0_req_i | m1_req_i;

`ifdef MEM_ARB_RR_EN
    always_comb begin
        gnt_own_o = OWN_M0;
        if (m0_req_i && m1_req_i) begin
            // rr_ptr_i holds the last winner, so the other master gets the tie.
            gnt_own_o = ~rr_ptr_i;
        end else if (m1_req_i) begin
            gnt_own_o = OWN_M1;
        end
    end
`else
    // History is irrelevant for fixed priority.
    logic unused_rr_ptr;
    assign unused_rr_ptr = rr_ptr_i;

    always_comb begin
        gnt_own_o = OWN_M0;
        if (!m0_req_i && m1_req_i) begin
            gnt_own_o = OWN_M1;
        end
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one unified instruction/data memory between m0 (multicycle CPU)
//   and m1 (program loader / debug DMA). Accesses are serialised: a winner is
//   picked in IDLE, its request is latched, the memory is enabled for MEM_LAT
//   cycles, then the winner gets a one-cycle ack with the read word.
//   Arbitration policy is selected by the MEM_ARB_RR_EN build macro
//   (round-robin when defined, fixed m0 priority otherwise).
// Parameters
//   ADDR_W  address width
//   DATA_W  data width
//   MEM_LAT cycles mem_en_o is held per access (>= 1)
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   mX_req_i                   request, held until mX_ack_o
//   mX_we_i / mX_addr_i /
//   mX_wdata_i                 access type, address, write data
//   mX_ack_o                   one-cycle completion pulse
//   mX_rdata_o                 read data, valid while mX_ack_o = 1
//   mem_en_o / mem_we_o        memory enable / write enable
//   mem_addr_o / mem_wdata_o   memory address / write data
//   mem_rdata_i                memory read data, valid in last access cycle
//   busy_o                     1 while not IDLE
//   owner_o                    master of current/last access (0 = m0)
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              owner_o
);

    if (MEM_LAT < 1) begin : g_lat_chk
        $error("mem_port_arbiter: MEM_LAT must be >= 1");
    end

    localparam int              CNT_W    = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              owner_q, owner_d;
    logic              rr_ptr_q, rr_ptr_d;

    logic gnt_any, gnt_own;

    mem_port_arbiter_pick u_pick (
        .m0_req_i  (m0_req_i),
        .m1_req_i  (m1_req_i),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_any_o (gnt_any),
        .gnt_own_o (gnt_own)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            owner_q  <= OWN_M0;
            // Pretend m1 was granted last so the first tie goes to m0.
            rr_ptr_q <= OWN_M1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (gnt_any) begin
                    state_d  = ARB_ACCESS;
                    cnt_d    = CNT_W'(1);
                    owner_d  = gnt_own;
                    rr_ptr_d = gnt_own;
                    // Latch the winner's request; master inputs are ignored
                    // from here until the next IDLE decision.
                    if (gnt_own == OWN_M1) begin
                        we_d    = m1_we_i;
                        addr_d  = m1_addr_i;
                        wdata_d = m1_wdata_i;
                    end else begin
                        we_d    = m0_we_i;
                        addr_d  = m0_addr_i;
                        wdata_d = m0_wdata_i;
                    end
                end
            end
            ARB_ACCESS: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ARB_DONE;
                    cnt_d   = '0;
                    rdata_d = we_q ? '0 : mem_rdata_i;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    logic in_access, in_done;
    assign in_access = (state_q == ARB_ACCESS);
    assign in_done   = (state_q == ARB_DONE);

    assign mem_en_o    = in_access;
    assign mem_we_o    = in_access & we_q;
    assign mem_addr_o  = in_access ? addr_q  : '0;
    assign mem_wdata_o = in_access ? wdata_q : '0;

    assign m0_ack_o   = in_done && (owner_q == OWN_M0);
    assign m1_ack_o   = in_done && (owner_q == OWN_M1);
    // The captured word is held until the next access completes.
    assign m0_rdata_o = rdata_q;
    assign m1_rdata_o = rdata_q;

    assign busy_o  = (state_q != ARB_IDLE);
    assign owner_o = owner_q;

endmodule
